hog_cell_fetcher: RTL and testbench

Responder for the HOG pipeline's cell-fetch handshake. On the consumer's `request`, it supplies one bordered cell of pixels on `o_data_fetch`, qualified by `ready`. It reads the frame from a single-port pixel memory (1-cycle read latency) and walks the cell grid in raster order. It sits between the frame buffer and the HOG/SVM core, taking the place of the bench driver on `ready`/`i_data_fetch`.

---
 rtl/hog_fetch_pkg.sv | 48 ++++
 rtl/hog_cell_fetcher_addr_gen.sv | 51 +++++
 rtl/hog_cell_fetcher.sv | 204 ++++++++++++++++++++
 tb/tb_hog_cell_fetcher.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hog_fetch_pkg.sv
// hog_fetch_pkg: shared constants, FSM state type and window-order helper
// for the HOG cell fetcher.
//   PIX_W  : pixel width
//   CELL_S : bordered cell side (8x8 cell plus 1-pixel border)
//   PIX_N  : pixels delivered per cell (bordered window minus its 4 corners)
//   pix_rc : maps pixel index k to its window (row, column)
package hog_fetch_pkg;

  localparam int PIX_W  = 8;
  localparam int CELL_S = 10;
  localparam int PIX_N  = CELL_S*CELL_S-4;
  localparam int K_W    = $clog2(PIX_N);
  localparam int RC_W   = $clog2(CELL_S);
  // Pixels in the first and last window rows once the corners are dropped.
  localparam int EDGE_N = CELL_S-2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSEMBLE = 2'd1,
    ST_HOLD     = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [RC_W-1:0] r;
    logic [RC_W-1:0] c;
  } pix_rc_t;

  // Row-major walk of the bordered window with the four corners skipped.
  function automatic pix_rc_t pix_rc(input logic [K_W-1:0] k);
    pix_rc_t rc;
    int      m;
    rc = '0;
    m  = 0;
    if (int'(k) < EDGE_N) begin
      rc.r = '0;
      rc.c = RC_W'(int'(k) + 1);
    end else if (int'(k) < PIX_N-EDGE_N) begin
      m    = int'(k) - EDGE_N;
      rc.r = RC_W'(m / CELL_S + 1);
      rc.c = RC_W'(m % CELL_S);
    end else begin
      rc.r = RC_W'(CELL_S-1);
      rc.c = RC_W'(int'(k) - (PIX_N-EDGE_N) + 1);
    end
    return rc;
  endfunction

endpackage

// File: rtl/hog_cell_fetcher_addr_gen.sv
// cell_addr_gen: combinational pixel address generator.
//   cell_x_i, cell_y_i : cell coordinates
//   pix_k_i            : pixel index within the bordered window
//   addr_o             : frame address y*IMG_W+x, clamped into the frame
//   oor_o              : requested pixel lies outside the frame
module cell_addr_gen
  import hog_fetch_pkg::*;
#(
  parameter int IMG_W   = 160,
  parameter int IMG_H   = 120,
  parameter int CX_W    = 5,
  parameter int CY_W    = 4,
  parameter int MADDR_W = 15
) (
  input  logic [CX_W-1:0]    cell_x_i,
  input  logic [CY_W-1:0]    cell_y_i,
  input  logic [K_W-1:0]     pix_k_i,
  output logic [MADDR_W-1:0] addr_o,
  output logic               oor_o
);

  pix_rc_t rc_s;
  int      x_s;
  int      y_s;
  int      xc_s;
  int      yc_s;

  // Window position to frame coordinates, then clamp to the nearest edge.
  always_comb begin
    rc_s  = pix_rc(pix_k_i);
    x_s   = int'(cell_x_i)*8 - 1 + int'(rc_s.c);
    y_s   = int'(cell_y_i)*8 - 1 + int'(rc_s.r);
    oor_o = (x_s < 0) || (x_s >= IMG_W) || (y_s < 0) || (y_s >= IMG_H);
    if (x_s < 0) begin
      xc_s = 0;
    end else if (x_s >= IMG_W) begin
      xc_s = IMG_W-1;
    end else begin
      xc_s = x_s;
    end
    if (y_s < 0) begin
      yc_s = 0;
    end else if (y_s >= IMG_H) begin
      yc_s = IMG_H-1;
    end else begin
      yc_s = y_s;
    end
    addr_o = MADDR_W'(yc_s*IMG_W + xc_s);
  end

endmodule

// File: rtl/hog_cell_fetcher.sv
// hog_cell_fetcher: walks the frame in raster cell order and, per cell,
// reads the 96-pixel bordered window from a 1-cycle-latency pixel memory,
// then holds it on o_data_fetch with ready until the consumer's request.
//   start/request       : frame start pulse / consumer wants a cell
//   ready/o_data_fetch  : complete cell available / packed pixels
//   mem_rd_en/mem_addr/mem_rdata : pixel memory read port
//   cell_x/cell_y       : cell currently held or being assembled
//   busy/frame_done     : not IDLE / pulse after the last transfer
// Option macro HOG_FETCH_EDGE_REPLICATE_EN: out-of-frame pixels take the
// clamped edge value instead of 0.
module hog_cell_fetcher #(
  parameter  int PIX_W   = 8,
  parameter  int CELL_S  = 10,
  parameter  int IMG_W   = 160,
  parameter  int IMG_H   = 120,
  localparam int PIX_N   = CELL_S*CELL_S-4,
  localparam int OUT_W   = PIX_W*PIX_N,
  localparam int MADDR_W = $clog2(IMG_W*IMG_H),
  localparam int CX_W    = $clog2(IMG_W/8),
  localparam int CY_W    = $clog2(IMG_H/8)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               request,
  output logic               ready,
  output logic [OUT_W-1:0]   o_data_fetch,
  output logic               mem_rd_en,
  output logic [MADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]   mem_rdata,
  output logic [CX_W-1:0]    cell_x,
  output logic [CY_W-1:0]    cell_y,
  output logic               busy,
  output logic               frame_done
);
  import hog_fetch_pkg::*;

  localparam logic [CX_W-1:0] CX_LAST = CX_W'(IMG_W/8-1);
  localparam logic [CY_W-1:0] CY_LAST = CY_W'(IMG_H/8-1);
  localparam logic [K_W-1:0]  K_LAST  = K_W'(PIX_N-1);

  fetch_state_e       state_q, state_d;
  logic [CX_W-1:0]    cell_x_q, cell_x_d;
  logic [CY_W-1:0]    cell_y_q, cell_y_d;
  logic [K_W-1:0]     rd_k_q, rd_k_d;
  logic               rd_en_q, rd_en_d;
  logic [MADDR_W-1:0] addr_q, addr_d;
  logic               rd_oor_q, rd_oor_d;
  logic               cap_en_q;
  logic [K_W-1:0]     cap_k_q;
  logic               cap_oor_q;
  logic [OUT_W-1:0]   data_q;
  logic               ready_q, busy_q, done_q, done_d;
  logic [PIX_W-1:0]   cap_pix_s;
  logic [MADDR_W-1:0] gen_addr_s;
  logic               gen_oor_s;
  logic               last_cell_s;

  assign last_cell_s = (cell_x_q == CX_LAST) && (cell_y_q == CY_LAST);

  // Address of the read about to be issued (next cell / next pixel index).
  cell_addr_gen #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .CX_W   (CX_W),
    .CY_W   (CY_W),
    .MADDR_W(MADDR_W)
  ) u_addr_gen (
    .cell_x_i(cell_x_d),
    .cell_y_i(cell_y_d),
    .pix_k_i (rd_k_d),
    .addr_o  (gen_addr_s),
    .oor_o   (gen_oor_s)
  );

  // Next-state logic; reads are registered so the first one lands in the
  // first ASSEMBLE cycle.
  always_comb begin
    state_d  = state_q;
    cell_x_d = cell_x_q;
    cell_y_d = cell_y_q;
    rd_en_d  = 1'b0;
    rd_k_d   = rd_k_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_ASSEMBLE;
          cell_x_d = '0;
          cell_y_d = '0;
          rd_en_d  = 1'b1;
          rd_k_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ASSEMBLE: begin
        if (rd_en_q && (rd_k_q != K_LAST)) begin
          rd_en_d = 1'b1;
          rd_k_d  = rd_k_q + K_W'(1);
        end else begin
          rd_en_d = 1'b0;
        end
        if (cap_en_q && (cap_k_q == K_LAST)) begin
          state_d = ST_HOLD;
        end else begin
          state_d = ST_ASSEMBLE;
        end
      end
      ST_HOLD: begin
        if (request) begin
          if (last_cell_s) begin
            state_d  = ST_IDLE;
            done_d   = 1'b1;
            cell_x_d = '0;
            cell_y_d = '0;
          end else begin
            state_d = ST_ASSEMBLE;
            rd_en_d = 1'b1;
            rd_k_d  = '0;
            if (cell_x_q == CX_LAST) begin
              cell_x_d = '0;
              cell_y_d = cell_y_q + CY_W'(1);
            end else begin
              cell_x_d = cell_x_q + CX_W'(1);
            end
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (rd_en_d) begin
      addr_d   = gen_addr_s;
      rd_oor_d = gen_oor_s;
    end else begin
      addr_d   = addr_q;
      rd_oor_d = rd_oor_q;
    end
  end

  // Pixel substituted for the captured read data.
  always_comb begin
`ifdef HOG_FETCH_EDGE_REPLICATE_EN
    cap_pix_s = mem_rdata;
`else
    if (cap_oor_q) begin
      cap_pix_s = '0;
    end else begin
      cap_pix_s = mem_rdata;
    end
`endif
  end

  // State, read pipeline (address -> capture) and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cell_x_q  <= '0;
      cell_y_q  <= '0;
      rd_k_q    <= '0;
      rd_en_q   <= 1'b0;
      addr_q    <= '0;
      rd_oor_q  <= 1'b0;
      cap_en_q  <= 1'b0;
      cap_k_q   <= '0;
      cap_oor_q <= 1'b0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cell_x_q  <= cell_x_d;
      cell_y_q  <= cell_y_d;
      rd_k_q    <= rd_k_d;
      rd_en_q   <= rd_en_d;
      addr_q    <= addr_d;
      rd_oor_q  <= rd_oor_d;
      cap_en_q  <= rd_en_q;
      cap_k_q   <= rd_k_q;
      cap_oor_q <= rd_oor_q;
      if (cap_en_q) begin
        data_q[cap_k_q*PIX_W +: PIX_W] <= cap_pix_s;
      end
      ready_q   <= (state_d == ST_HOLD);
      busy_q    <= (state_d != ST_IDLE);
      done_q    <= done_d;
    end
  end

  assign ready        = ready_q;
  assign o_data_fetch = data_q;
  assign mem_rd_en    = rd_en_q;
  assign mem_addr     = addr_q;
  assign cell_x       = cell_x_q;
  assign cell_y       = cell_y_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_hog_cell_fetcher.sv
// Scoreboard bench for hog_cell_fetcher on a 16x16 frame (2x2 cells) with
// memory content mem[a] = a & 0xFF.
module tb_hog_cell_fetcher;

  localparam int IMG_W = 16;
  localparam int IMG_H = 16;
  localparam int OUT_W = 8*96;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             request;
  logic             ready;
  logic [OUT_W-1:0] o_data_fetch;
  logic             mem_rd_en;
  logic [7:0]       mem_addr;
  logic [7:0]       mem_rdata = 8'h00;
  logic [0:0]       cell_x;
  logic [0:0]       cell_y;
  logic             busy;
  logic             frame_done;

  logic [7:0] mem [0:255];

  int err_cnt = 0;
  int chk_cnt = 0;

  typedef struct {
    int               cx;
    int               cy;
    logic [OUT_W-1:0] data;
  } exp_t;
  exp_t sb[$];

  hog_cell_fetcher #(
    .PIX_W (8),
    .CELL_S(10),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .request     (request),
    .ready       (ready),
    .o_data_fetch(o_data_fetch),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .cell_x      (cell_x),
    .cell_y      (cell_y),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  // Single-port pixel memory, 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  task automatic check(input string name, input logic [OUT_W-1:0] act,
                       input logic [OUT_W-1:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference window: bordered 10x10 around the cell, corners dropped.
  function automatic logic [OUT_W-1:0] model_cell(input int cx, input int cy);
    logic [OUT_W-1:0] v;
    int k, x, y, xc, yc;
    logic [7:0] p;
    v = '0;
    k = 0;
    for (int r = 0; r < 10; r++) begin
      for (int c = 0; c < 10; c++) begin
        if ((r == 0 || r == 9) && (c == 0 || c == 9)) continue;
        x  = 8*cx - 1 + c;
        y  = 8*cy - 1 + r;
        xc = (x < 0) ? 0 : ((x >= IMG_W) ? IMG_W-1 : x);
        yc = (y < 0) ? 0 : ((y >= IMG_H) ? IMG_H-1 : y);
        if (x == xc && y == yc) p = mem[y*IMG_W + x];
`ifdef HOG_FETCH_EDGE_REPLICATE_EN
        else p = mem[yc*IMG_W + xc];
`else
        else p = 8'h00;
`endif
        v[k*8 +: 8] = p;
        k++;
      end
    end
    return v;
  endfunction

  task automatic push_frame();
    exp_t e;
    for (int cy = 0; cy < IMG_H/8; cy++) begin
      for (int cx = 0; cx < IMG_W/8; cx++) begin
        e.cx = cx;
        e.cy = cy;
        e.data = model_cell(cx, cy);
        sb.push_back(e);
      end
    end
  endtask

  // Monitor: pops the scoreboard on every transfer and checks handshake rules.
  logic             exp_done  = 1'b0;
  logic             prev_rdy  = 1'b0;
  logic             prev_xfer = 1'b0;
  logic [OUT_W-1:0] prev_data = '0;
  logic             xfer;
  exp_t             mon_e;
  logic [7:0]       p95_exp;

  always @(negedge clk) begin
`ifdef HOG_FETCH_EDGE_REPLICATE_EN
    p95_exp = 8'hFF;
`else
    p95_exp = 8'h00;
`endif
    xfer = (ready === 1'b1) && (request === 1'b1);
    check("frame_done pulse", frame_done, exp_done);
    exp_done = 1'b0;
    if (prev_xfer) check("ready low after transfer", ready, 0);
    if (prev_rdy && (ready === 1'b1) && !prev_xfer) begin
      check("hold data stable", o_data_fetch, prev_data);
      check("no read in hold", mem_rd_en, 0);
    end
    if (xfer) begin
      if (sb.size() == 0) begin
        check("unexpected transfer", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check("cell_x", cell_x, mon_e.cx);
        check("cell_y", cell_y, mon_e.cy);
        check("cell data", o_data_fetch, mon_e.data);
        if (mon_e.cx == 1 && mon_e.cy == 1) begin
          check("cell11 pixel7", o_data_fetch[7*8 +: 8], 8'h7F);
          check("cell11 pixel95", o_data_fetch[95*8 +: 8], p95_exp);
        end
        if (sb.size() == 0) exp_done = 1'b1;
      end
    end
    prev_rdy  = (ready === 1'b1);
    prev_xfer = xfer;
    prev_data = o_data_fetch;
  end

  task automatic wait_done(input bit rand_req);
    int n;
    n = 0;
    while (n < 3000) begin
      @(posedge clk); #1;
      if (frame_done) break;
      if (rand_req) request = ($urandom_range(0, 3) != 0);
      n++;
    end
    check("frame_done reached", frame_done, 1);
  endtask

  task automatic start_frame();
    push_frame();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [OUT_W-1:0] held;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    rst = 1'b1; start = 1'b0; request = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", ready, 0);
    check("reset busy", busy, 0);
    check("reset rd_en", mem_rd_en, 0);
    check("reset frame_done", frame_done, 0);
    check("reset data", o_data_fetch, 0);
    check("reset addr", mem_addr, 0);
    check("reset cell", {cell_y, cell_x}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Frame 1: request held high, measure start-to-ready latency.
    request = 1'b1;
    push_frame();
    start = 1'b1;
    n = 0;
    while (n < 300) begin
      @(posedge clk); #1;
      start = 1'b0;
      n++;
      if (ready) break;
    end
    check("start to ready latency", n, 98);
    check("cell00 pixel9", o_data_fetch[9*8 +: 8], 8'h00);
    check("cell00 pixel17", o_data_fetch[17*8 +: 8], 8'h08);
    check("cell00 pixel0", o_data_fetch[0 +: 8], 8'h00);
    wait_done(1'b0);
    check("idle at frame_done", busy, 0);

    // Frame 2: start in the frame_done cycle, random request pattern.
    start_frame();
    check("start accepted on frame_done", busy, 1);
    wait_done(1'b1);
    @(posedge clk); #1;
    check("frame_done single pulse", frame_done, 0);

    // Frame 3: stray start during ASSEMBLE, then a 20-cycle stall in HOLD.
    request = 1'b0;
    push_frame();
    start = 1'b1;
    n = 0;
    while (n < 300) begin
      @(posedge clk); #1;
      n++;
      start = (n == 10);
      if (ready) break;
    end
    check("latency with stray start", n, 98);
    held = o_data_fetch;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("ready held in stall", ready, 1);
      check("data held in stall", o_data_fetch, held);
    end
    request = 1'b1;
    @(posedge clk); #1;
    check("ready drops after stall", ready, 0);
    check("next read issued", mem_rd_en, 1);
    check("advance to cell(1,0)", {cell_y, cell_x}, 2'b01);
    wait_done(1'b0);

    // Frame 4: reset in cycle 50 of ASSEMBLE, then restart.
    start_frame();
    repeat (50) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    check("abort ready", ready, 0);
    check("abort busy", busy, 0);
    check("abort rd_en", mem_rd_en, 0);
    check("abort data", o_data_fetch, 0);
    check("abort addr", mem_addr, 0);
    check("abort cell", {cell_y, cell_x}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("no frame_done after abort", frame_done, 0);
    start_frame();
    wait_done(1'b1);
    @(posedge clk); #1;
    check("scoreboard drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
